// File: rtl/regfile_pkg.sv
// Shared widths, tag constants and table types for the rename register file.
package regfile_pkg;

    localparam int DataBus     = 32;
    localparam int TagBus      = 4;
    localparam int TagRootBus  = 3;
    localparam int RegAddrBus  = 5;
    localparam int NumRegs     = 32;
    localparam int BranchSlots = 4;
    localparam int BranchBus   = 2;

    localparam logic [TagBus-1:0]  tagFree  = 4'b1000;
    localparam logic [DataBus-1:0] dataFree = '0;
    localparam logic               Enable   = 1'b1;
    localparam logic               Disable  = 1'b0;

    typedef logic [DataBus-1:0]    data_t;
    typedef logic [TagBus-1:0]     tag_t;
    typedef logic [RegAddrBus-1:0] reg_addr_t;
    typedef logic [BranchBus-1:0]  branch_t;
    typedef tag_t  [NumRegs-1:0]   tag_tbl_t;
    typedef data_t [NumRegs-1:0]   data_tbl_t;

    // Retire a tag everywhere it appears in a table.
    function automatic tag_tbl_t commit_clear(input tag_tbl_t tbl, input logic en, input tag_t t);
        tag_tbl_t res;
        for (int i = 0; i < NumRegs; i++) begin
            res[i] = (en && tbl[i] == t) ? tagFree : tbl[i];
        end
        return res;
    endfunction

endpackage

// File: rtl/regfile_ckpt.sv
// Four-slot checkpoint store of the rename tag table: capture, commit-clear, restore-read.
import regfile_pkg::*;

module regfile_ckpt (
    input  logic     clk,
    input  logic     rst,
    input  logic     rdy,
    input  logic     cap_en,
    input  branch_t  cap_slot,
    input  tag_tbl_t cap_tbl,
    input  logic     clr_en,
    input  tag_t     clr_tag,
    input  branch_t  rd_slot,
    output tag_tbl_t rd_tbl
);

    tag_tbl_t ckpt_q [BranchSlots];
    tag_tbl_t ckpt_d [BranchSlots];

    // A capture overrides the clear; the captured table is already cleared by the caller.
    always_comb begin
        for (int s = 0; s < BranchSlots; s++) begin
            ckpt_d[s] = commit_clear(ckpt_q[s], clr_en, clr_tag);
            if (cap_en && cap_slot == branch_t'(s)) begin
                ckpt_d[s] = cap_tbl;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < BranchSlots; s++) begin
                ckpt_q[s] <= {NumRegs{tagFree}};
            end
        end else if (rdy) begin
            for (int s = 0; s < BranchSlots; s++) begin
                ckpt_q[s] <= ckpt_d[s];
            end
        end
    end

    assign rd_tbl = ckpt_q[rd_slot];

endmodule

// File: rtl/regfile.sv
// Renaming architectural register file with branch checkpoints.
// Define REGFILE_COMMIT_BYPASS_EN to forward commit data/tag to the read ports in the commit cycle.
import regfile_pkg::*;

module regfile (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  enComI,
    input  logic [TagBus-1:0]     ComTagI,
    input  logic [DataBus-1:0]    ComDataI,
    input  logic                  enDisp,
    input  logic [RegAddrBus-1:0] dispRd,
    input  logic [TagBus-1:0]     dispTag,
    input  logic [RegAddrBus-1:0] rs1Addr,
    input  logic [RegAddrBus-1:0] rs2Addr,
    output logic [DataBus-1:0]    rs1Data,
    output logic [DataBus-1:0]    rs2Data,
    output logic [TagBus-1:0]     rs1Tag,
    output logic [TagBus-1:0]     rs2Tag,
    input  logic                  enBranch,
    input  logic [BranchBus-1:0]  branchNum,
    input  logic                  bFreeEn,
    input  logic [BranchBus-1:0]  bFreeNum,
    input  logic                  misTaken
);

    data_tbl_t data_q, data_d;
    tag_tbl_t  tag_q, tag_d;
    tag_tbl_t  tag_clr, tag_ren, ck_rd, ck_restored;
    logic      rollback;

    assign rollback = bFreeEn && misTaken;

    regfile_ckpt u_ckpt (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .cap_en   (enBranch && !rollback),
        .cap_slot (branchNum),
        .cap_tbl  (tag_ren),
        .clr_en   (enComI),
        .clr_tag  (ComTagI),
        .rd_slot  (bFreeNum),
        .rd_tbl   (ck_rd)
    );

    always_comb begin
        data_d      = data_q;
        tag_clr     = commit_clear(tag_q, enComI, ComTagI);
        ck_restored = commit_clear(ck_rd, enComI, ComTagI);
        for (int i = 1; i < NumRegs; i++) begin
            if (enComI && tag_q[i] == ComTagI) begin
                data_d[i] = ComDataI;
            end
        end
        data_d[0] = dataFree;

        // Rename wins over the commit clear on the same register.
        tag_ren = tag_clr;
        if (enDisp && dispRd != '0) begin
            tag_ren[dispRd] = dispTag;
        end
        tag_ren[0] = tagFree;

        tag_d    = rollback ? ck_restored : tag_ren;
        tag_d[0] = tagFree;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= {NumRegs{dataFree}};
            tag_q  <= {NumRegs{tagFree}};
        end else if (rdy) begin
            data_q <= data_d;
            tag_q  <= tag_d;
        end
    end

    always_comb begin
        rs1Data = data_q[rs1Addr];
        rs1Tag  = tag_q[rs1Addr];
        rs2Data = data_q[rs2Addr];
        rs2Tag  = tag_q[rs2Addr];
`ifdef REGFILE_COMMIT_BYPASS_EN
        if (rdy && enComI && rs1Addr != '0 && tag_q[rs1Addr] == ComTagI) begin
            rs1Data = ComDataI;
            rs1Tag  = tagFree;
        end
        if (rdy && enComI && rs2Addr != '0 && tag_q[rs2Addr] == ComTagI) begin
            rs2Data = ComDataI;
            rs2Tag  = tagFree;
        end
`else
        // Reads reflect registered state only.
`endif
    end

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset.
REQ-003 rdy  input  1  global enable; when low, all state holds and outputs stay consistent with held state.
REQ-004 enComI, ComTagI, ComDataI  input  1/4/32  ROB commit port (valid, tag, data); ROB tags are 0..7, tagFree=4'b1000.
REQ-005 enDisp, dispRd, dispTag  input  1/5/4  dispatch rename: architectural rd gets ROB tag dispTag.
REQ-006 rs1Addr, rs2Addr  input  5/5  dispatcher source-operand read addresses.
REQ-007 rs1Data, rs2Data  output  32/32  architectural value, or bypassed commit value (see REQ-019).
REQ-008 rs1Tag, rs2Tag  output  4/4  pending ROB tag, or tagFree when the value is final.
REQ-009 enBranch, branchNum  input  1/2  dispatcher allocates branch slot branchNum; checkpoint is taken.
REQ-010 bFreeEn, bFreeNum, misTaken  input  1/2/1  branch resolve: slot bFreeNum released; misTaken means roll back to that slot.

Function
REQ-011 Storage: 32x32 data array, 32x4 tag table, 4 checkpoint copies of the tag table (4x32x4).
REQ-012 x0 reads as 0 with tagFree always; commits and renames to x0 are ignored.
REQ-013 Commit (enComI): write ComDataI to every register whose tag equals ComTagI; in the same edge, set those tags to tagFree.
REQ-014 Commit tag clear also applies to every checkpoint entry equal to ComTagI, so restored checkpoints never hold retired tags.
REQ-015 Rename (enDisp, dispRd!=0): tag[dispRd] <= dispTag; takes priority over a same-cycle commit clear on that register; the commit data write still occurs.
REQ-016 Checkpoint (enBranch): checkpoint[branchNum] <= tag table after this cycle's commit clear and rename, so a branch's own rd (jal/jalr) survives rollback.
REQ-017 Rollback (misTaken): tag table <= checkpoint[bFreeNum], with this cycle's commit clear applied to the restored copy; any same-cycle enDisp or enBranch is ignored.
REQ-018 bFreeEn without misTaken: no state change; the slot becomes reusable.
REQ-019 Reads are combinational, zero latency: rsxTag=tag[rsxAddr]; rsxData=data[rsxAddr], except when REQ-027 bypass applies.
REQ-020 A rename in cycle N is visible to reads from cycle N+1; a read in cycle N returns the pre-rename tag.
REQ-021 Multiple registers may hold the same tag only transiently; all are updated by one commit (REQ-013).

Reset
REQ-022 On rst low (async): all data words 0, all tags and checkpoint entries tagFree.
REQ-023 Reset mid-operation discards pending renames and checkpoints; rsxTag=tagFree and rsxData=0 while rst is low.
REQ-024 Reset release is synchronous to clk; first update on the first rising edge with rst high and rdy high.

Configuration
REQ-025 Macro REGFILE_COMMIT_BYPASS_EN selects commit-to-read forwarding.
REQ-026 Without it: reads reflect registered state only; a commit of tag T in cycle N shows as data/tagFree from cycle N+1.
REQ-027 With it: if enComI and tag[rsxAddr]==ComTagI, then rsxData=ComDataI and rsxTag=tagFree in the same cycle.

Structure
REQ-028 The shared defines file holds DataBus, TagBus, TagRootBus, RegAddrBus, tagFree, dataFree, Enable/Disable and the branch-slot count (4).
REQ-029 One sub-module, regfile_ckpt: the 4-slot checkpoint store with capture, commit-clear and restore-read ports.

Verification
REQ-030 Reset, then read x5 -> rs1Data=0, rs1Tag=4'b1000.
REQ-031 Rename x5->tag 3; next cycle commit tag 3 with 0xDEADBEEF -> the cycle after, x5 reads 0xDEADBEEF with tagFree. With bypass, the same values appear in the commit cycle.
REQ-032 Same cycle: commit tag 2 to x7 (tag 2) and rename x7->tag 6 -> data 0x…=ComData written, tag[x7]=6.
REQ-033 Rename x1->1; enBranch slot 0 with rename x2->2; then rename x3->4; misTaken bFreeNum=0 -> x1=1, x2=2, x3=tagFree.
REQ-034 Checkpoint slot 1 holding x4->5; commit tag 5; then misTaken slot 1 -> x4 tagFree and data equals the committed value.
REQ-035 Rename x0->3 and commit tag 3 -> x0 stays 0/tagFree; assert rst mid-stream -> all tags tagFree immediately.
